dual_mem_responder: RTL and testbench

DUAL_MEM_RESPONDER -- requirements
Module: dual_mem_responder

---
 rtl/dual_mem_responder.sv | 193 +++++++++++++++++++
 tb/tb_dual_mem_responder.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/dual_mem_responder.sv
// ----------------------------------------------------------------------------
// dual_mem_responder
//
// Behavioural memory model with two independent request ports: an instruction
// fetch port (I) and a data port (D). Both ports share one word-addressed
// storage array of 2^ADDR_BITS 32-bit words. Each port accepts a request when
// idle, waits LATENCY cycles and then emits a single-cycle response pulse.
//
// Parameters
//   LATENCY    cycles from request acceptance to response (1..15)
//   ADDR_BITS  log2 of the storage depth in words
//
// Ports
//   clk           clock, rising edge
//   rst           synchronous active-high reset (storage is not cleared)
//   imem_addr     instruction byte address
//   imem_rmask    instruction read mask, nonzero = request present
//   imem_rdata    instruction read data, zero unless imem_resp
//   imem_resp     instruction response pulse
//   dmem_addr     data byte address
//   dmem_rmask    data read mask
//   dmem_wmask    data write byte-lane mask
//   dmem_wdata    data write data
//   dmem_rdata    data read data, zero unless dmem_resp
//   dmem_resp     data response pulse (reads and writes)
//   protocol_err  pulse when a data request has both read and write masks set
// ----------------------------------------------------------------------------
module dual_mem_responder #(
    parameter int LATENCY   = 2,
    parameter int ADDR_BITS = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] imem_addr,
    input  logic [3:0]  imem_rmask,
    output logic [31:0] imem_rdata,
    output logic        imem_resp,
    input  logic [31:0] dmem_addr,
    input  logic [3:0]  dmem_rmask,
    input  logic [3:0]  dmem_wmask,
    input  logic [31:0] dmem_wdata,
    output logic [31:0] dmem_rdata,
    output logic        dmem_resp,
    output logic        protocol_err
);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    localparam int          DEPTH     = 1 << ADDR_BITS;
    localparam logic [3:0]  CNT_LOAD  = 4'(LATENCY - 1);
    // With LATENCY=1 the response falls in the cycle right after acceptance,
    // so the response flag must already be raised by the accepting edge.
    localparam logic        LOAD_RESP = (LATENCY == 1);

    logic [31:0] mem [DEPTH];

    // Address bits outside the word index are deliberately ignored (aliasing).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{imem_addr[31:ADDR_BITS+2], imem_addr[1:0],
                                dmem_addr[31:ADDR_BITS+2], dmem_addr[1:0]};

    // ------------------------------------------------------------------
    // Instruction port FSM. The response flag is registered and is high
    // exactly while the FSM sits in BUSY with the counter at zero.
    // ------------------------------------------------------------------
    state_t                 i_state;
    logic [3:0]             i_cnt;
    logic [ADDR_BITS-1:0]   i_idx;
    logic                   i_resp_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            i_state  <= IDLE;
            i_cnt    <= '0;
            i_idx    <= '0;
            i_resp_q <= 1'b0;
        end else begin
            case (i_state)
                IDLE: begin
                    i_resp_q <= 1'b0;
                    if (imem_rmask != 4'b0) begin
                        i_idx    <= imem_addr[ADDR_BITS+1:2];
                        i_cnt    <= CNT_LOAD;
                        i_resp_q <= LOAD_RESP;
                        i_state  <= BUSY;
                    end
                end
                BUSY: begin
                    if (i_cnt != 4'd0) begin
                        i_cnt    <= i_cnt - 4'd1;
                        i_resp_q <= (i_cnt == 4'd1);
                    end else begin
                        i_resp_q <= 1'b0;
                        i_state  <= IDLE;
                    end
                end
                default: begin
                    i_resp_q <= 1'b0;
                    i_state  <= IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Data port FSM. A request carrying any write lane is handled as a
    // write, even when a read mask is present as well.
    // ------------------------------------------------------------------
    state_t                 d_state;
    logic [3:0]             d_cnt;
    logic [ADDR_BITS-1:0]   d_idx;
    logic [3:0]             d_wmask;
    logic [31:0]            d_wdata;
    logic                   d_write;
    logic                   d_resp_q;
    logic                   d_req;

    assign d_req = (dmem_rmask != 4'b0) || (dmem_wmask != 4'b0);

    always_ff @(posedge clk) begin
        if (rst) begin
            d_state  <= IDLE;
            d_cnt    <= '0;
            d_idx    <= '0;
            d_wmask  <= '0;
            d_wdata  <= '0;
            d_write  <= 1'b0;
            d_resp_q <= 1'b0;
        end else begin
            case (d_state)
                IDLE: begin
                    d_resp_q <= 1'b0;
                    if (d_req) begin
                        d_idx    <= dmem_addr[ADDR_BITS+1:2];
                        d_wmask  <= dmem_wmask;
                        d_wdata  <= dmem_wdata;
                        d_write  <= (dmem_wmask != 4'b0);
                        d_cnt    <= CNT_LOAD;
                        d_resp_q <= LOAD_RESP;
                        d_state  <= BUSY;
                    end
                end
                BUSY: begin
                    if (d_cnt != 4'd0) begin
                        d_cnt    <= d_cnt - 4'd1;
                        d_resp_q <= (d_cnt == 4'd1);
                    end else begin
                        d_resp_q <= 1'b0;
                        d_state  <= IDLE;
                    end
                end
                default: begin
                    d_resp_q <= 1'b0;
                    d_state  <= IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Storage write. The commit happens on the edge that ends the D
    // response cycle, so a same-cycle I read still sees the old word and
    // any read responding one cycle later sees the new one. Reset in the
    // response cycle suppresses the commit.
    // ------------------------------------------------------------------
    logic d_commit;
    assign d_commit = d_resp_q && d_write && !rst;

    always_ff @(posedge clk) begin
        if (d_commit) begin
            for (int b = 0; b < 4; b++) begin
                if (d_wmask[b]) begin
                    mem[d_idx][8*b +: 8] <= d_wdata[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs. Responses are forced low while reset is held, and read data
    // is zero whenever its response is low.
    // ------------------------------------------------------------------
    assign imem_resp    = i_resp_q && !rst;
    assign dmem_resp    = d_resp_q && !rst;
    assign imem_rdata   = imem_resp ? mem[i_idx] : 32'h0;
    assign dmem_rdata   = dmem_resp ? mem[d_idx] : 32'h0;
    assign protocol_err = !rst && (d_state == IDLE) &&
                          (dmem_rmask != 4'b0) && (dmem_wmask != 4'b0);

endmodule

// File: tb/tb_dual_mem_responder.sv
// ----------------------------------------------------------------------------
// tb_dual_mem_responder
//
// Directed self-checking bench for dual_mem_responder with LATENCY=2 and
// ADDR_BITS=10. Inputs change 1 time unit after a rising edge; outputs are
// sampled on the falling edge of the same cycle.
// ----------------------------------------------------------------------------
module tb_dual_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic [3:0]  imem_rmask;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_rmask;
    logic [3:0]  dmem_wmask;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;
    logic        protocol_err;

    int checks = 0;
    int errors = 0;

    dual_mem_responder #(
        .LATENCY   (2),
        .ADDR_BITS (10)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_addr    (imem_addr),
        .imem_rmask   (imem_rmask),
        .imem_rdata   (imem_rdata),
        .imem_resp    (imem_resp),
        .dmem_addr    (dmem_addr),
        .dmem_rmask   (dmem_rmask),
        .dmem_wmask   (dmem_wmask),
        .dmem_wdata   (dmem_wdata),
        .dmem_rdata   (dmem_rdata),
        .dmem_resp    (dmem_resp),
        .protocol_err (protocol_err)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One D transaction: present in cycle t, response checked in cycle t+2,
    // returns at the start of cycle t+3 with the port idle.
    task automatic applyStimulus(input string tag, input logic [31:0] addr,
                                 input logic [3:0] rmask, input logic [3:0] wmask,
                                 input logic [31:0] wdata, input logic check_data,
                                 input logic [31:0] exp_data, input logic exp_err);
        dmem_addr  = addr;
        dmem_rmask = rmask;
        dmem_wmask = wmask;
        dmem_wdata = wdata;
        @(negedge clk);
        checkOutput($sformatf("%s_err_t0", tag), {31'b0, protocol_err}, {31'b0, exp_err});
        checkOutput($sformatf("%s_resp_t0", tag), {31'b0, dmem_resp}, 32'd0);
        tick();
        dmem_addr  = 32'hFFFF_FFFC;
        dmem_rmask = 4'h0;
        dmem_wmask = 4'h0;
        dmem_wdata = 32'h0;
        @(negedge clk);
        checkOutput($sformatf("%s_resp_t1", tag), {31'b0, dmem_resp}, 32'd0);
        checkOutput($sformatf("%s_rdata_t1", tag), dmem_rdata, 32'd0);
        tick();
        @(negedge clk);
        checkOutput($sformatf("%s_resp_t2", tag), {31'b0, dmem_resp}, 32'd1);
        if (check_data)
            checkOutput($sformatf("%s_rdata_t2", tag), dmem_rdata, exp_data);
        tick();
    endtask

    // One I fetch with the same timing as the D transaction above.
    task automatic iRead(input string tag, input logic [31:0] addr,
                         input logic [31:0] exp_data);
        imem_addr  = addr;
        imem_rmask = 4'hF;
        @(negedge clk);
        checkOutput($sformatf("%s_iresp_t0", tag), {31'b0, imem_resp}, 32'd0);
        tick();
        imem_addr  = 32'h0;
        imem_rmask = 4'h0;
        @(negedge clk);
        checkOutput($sformatf("%s_iresp_t1", tag), {31'b0, imem_resp}, 32'd0);
        checkOutput($sformatf("%s_irdata_t1", tag), imem_rdata, 32'd0);
        tick();
        @(negedge clk);
        checkOutput($sformatf("%s_iresp_t2", tag), {31'b0, imem_resp}, 32'd1);
        checkOutput($sformatf("%s_irdata_t2", tag), imem_rdata, exp_data);
        tick();
    endtask

    initial begin
        rst        = 1'b1;
        imem_addr  = 32'h0;
        imem_rmask = 4'h0;
        dmem_addr  = 32'h0;
        dmem_rmask = 4'h0;
        dmem_wmask = 4'h0;
        dmem_wdata = 32'h0;

        // Reset state
        tick();
        tick();
        imem_rmask = 4'hF;
        dmem_rmask = 4'hF;
        dmem_wmask = 4'hF;
        @(negedge clk);
        checkOutput("rst_iresp", {31'b0, imem_resp}, 32'd0);
        checkOutput("rst_dresp", {31'b0, dmem_resp}, 32'd0);
        checkOutput("rst_perr", {31'b0, protocol_err}, 32'd0);
        checkOutput("rst_irdata", imem_rdata, 32'd0);
        checkOutput("rst_drdata", dmem_rdata, 32'd0);
        tick();
        imem_rmask = 4'h0;
        dmem_rmask = 4'h0;
        dmem_wmask = 4'h0;
        tick();
        rst = 1'b0;

        // Write then read, first request in the first cycle out of reset
        applyStimulus("wr40", 32'h40, 4'h0, 4'hF, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0);
        applyStimulus("rd40", 32'h40, 4'hF, 4'h0, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0);

        // Byte-lane write, read back through the I port
        applyStimulus("wr42", 32'h42, 4'h0, 4'h4, 32'h00AA0000, 1'b0, 32'h0, 1'b0);
        iRead("ird40", 32'h40, 32'hDEAABEEF);

        // Held fetch: responses every third cycle
        applyStimulus("wr00", 32'h0, 4'h0, 4'hF, 32'h01234567, 1'b0, 32'h0, 1'b0);
        imem_addr  = 32'h0;
        imem_rmask = 4'hF;
        for (int i = 0; i < 10; i++) begin
            if (i == 9) imem_rmask = 4'h0;
            @(negedge clk);
            checkOutput($sformatf("held_c%0d", i), {31'b0, imem_resp},
                        ((i % 3) == 2) ? 32'd1 : 32'd0);
            if ((i % 3) == 2)
                checkOutput($sformatf("held_data_c%0d", i), imem_rdata, 32'h01234567);
            tick();
        end

        // Simultaneous I read and D write to the same word
        applyStimulus("wr80", 32'h80, 4'h0, 4'hF, 32'h11111111, 1'b0, 32'h0, 1'b0);
        imem_addr  = 32'h80;
        imem_rmask = 4'hF;
        dmem_addr  = 32'h80;
        dmem_wmask = 4'hF;
        dmem_wdata = 32'h22222222;
        tick();
        imem_rmask = 4'h0;
        dmem_wmask = 4'h0;
        tick();
        @(negedge clk);
        checkOutput("sim_iresp", {31'b0, imem_resp}, 32'd1);
        checkOutput("sim_dresp", {31'b0, dmem_resp}, 32'd1);
        checkOutput("sim_irdata", imem_rdata, 32'h11111111);
        tick();
        iRead("sim_after", 32'h80, 32'h22222222);

        // Read responding the cycle after a write response sees new data
        dmem_addr  = 32'hC0;
        dmem_wmask = 4'hF;
        dmem_wdata = 32'hA5A5A5A5;
        tick();
        dmem_wmask = 4'h0;
        imem_addr  = 32'hC0;
        imem_rmask = 4'hF;
        tick();
        imem_rmask = 4'h0;
        @(negedge clk);
        checkOutput("fwd_dresp", {31'b0, dmem_resp}, 32'd1);
        checkOutput("fwd_iresp_early", {31'b0, imem_resp}, 32'd0);
        tick();
        @(negedge clk);
        checkOutput("fwd_iresp", {31'b0, imem_resp}, 32'd1);
        checkOutput("fwd_irdata", imem_rdata, 32'hA5A5A5A5);
        tick();

        // Reset in the middle of a write drops it
        applyStimulus("wr100", 32'h100, 4'h0, 4'hF, 32'hCAFEF00D, 1'b0, 32'h0, 1'b0);
        dmem_addr  = 32'h100;
        dmem_wmask = 4'hF;
        dmem_wdata = 32'h0BADBEEF;
        tick();
        dmem_wmask = 4'h0;
        rst        = 1'b1;
        @(negedge clk);
        checkOutput("rstmid_resp_t1", {31'b0, dmem_resp}, 32'd0);
        tick();
        @(negedge clk);
        checkOutput("rstmid_resp_t2", {31'b0, dmem_resp}, 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rstmid_resp_t3", {31'b0, dmem_resp}, 32'd0);
        tick();
        applyStimulus("rd100", 32'h100, 4'hF, 4'h0, 32'h0, 1'b1, 32'hCAFEF00D, 1'b0);
        applyStimulus("rd40_kept", 32'h40, 4'hF, 4'h0, 32'h0, 1'b1, 32'hDEAABEEF, 1'b0);

        // Illegal mask combination is flagged and treated as a write
        applyStimulus("illegal", 32'h100, 4'hF, 4'h1, 32'h55555555, 1'b0, 32'h0, 1'b1);
        applyStimulus("rd100_b0", 32'h100, 4'hF, 4'h0, 32'h0, 1'b1, 32'hCAFEF055, 1'b0);

        // High address bits alias onto the low words
        applyStimulus("wr1040", 32'h1040, 4'h0, 4'hF, 32'h13579BDF, 1'b0, 32'h0, 1'b0);
        applyStimulus("rd_alias", 32'h40, 4'hF, 4'h0, 32'h0, 1'b1, 32'h13579BDF, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
